// File: rtl/clk_div_multi.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | clk_div_multi: N_CH programmable dividers with shadowed, wrap-aligned config |
// | Optional macro CLK_DIV_SYNC_EN adds sync_all to phase-align all channels.   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module clk_div_multi #(
  parameter int unsigned  N_CH    = 4,
  parameter int unsigned  DIV_W   = 32,
  parameter int unsigned  DEF_DIV = 5000,
  parameter bit           DEF_EN  = 1'b1,
  localparam int unsigned CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_all,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending
);

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE       = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [N_CH-1:0] chan_sel;
  logic            accept;
  logic            sync_hit;

`ifdef CLK_DIV_SYNC_EN
  assign sync_hit = sync_all;
`else
  assign sync_hit = 1'b0;
`endif

  // An out-of-range channel selects nothing, so it is always ready and the write is dropped.
  assign cfg_ready = !reset && !(|(chan_sel & pending));
  assign accept    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] sh_div;
    logic             en_act;
    logic             sh_en;
    logic             clk_q;
    logic             tick_q;
    logic             pend;
    logic             run;
    logic             sh_run;
    logic             wrap;
    logic             apply;

    assign chan_sel[i] = (cfg_chan == CHW'(i));

    assign run    = en_act && (div_act != '0);
    assign sh_run = sh_en && (sh_div != '0);
    assign wrap   = run && (cnt == div_act - ONE);
    // Running channels only take a new config at a period boundary; idle ones take it at once.
    assign apply  = pend && (wrap || !run);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt     <= '0;
        div_act <= DEF_DIV_V;
        en_act  <= DEF_EN;
        sh_div  <= '0;
        sh_en   <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        pend    <= 1'b0;
      end else begin
        if (sync_hit || apply) begin
          if (pend) begin
            div_act <= sh_div;
            en_act  <= sh_en;
            pend    <= 1'b0;
          end
          cnt <= '0;
          // The wrap that completes the old period still toggles, unless the new config idles.
          if (!sync_hit && wrap && sh_run) begin
            clk_q  <= ~clk_q;
            tick_q <= 1'b1;
          end else begin
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
          end
        end else if (wrap) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
        end else if (run) begin
          cnt    <= cnt + ONE;
          tick_q <= 1'b0;
        end else begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end

        // Never collides with the clear above: a pending channel is not ready.
        if (accept && chan_sel[i]) begin
          sh_div <= cfg_div;
          sh_en  <= cfg_en;
          pend   <= 1'b1;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// Bench for clk_div_multi: directed vector table, hand sequences and a timestamp-based reference model.
module tb_clk_div_multi;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int DD = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [1:0]    chan = '0;
  logic [DW-1:0] div = '0;
  logic          en = 1'b0;
  logic          sy = 1'b0;
  logic          cfg_ready;
  logic [N-1:0]  clk_out, tick, pending;

  logic          b_rst = 1'b1;
  logic          b_vld = 1'b0;
  logic [1:0]    b_chan = '0;
  logic [DW-1:0] b_div = '0;
  logic          b_ready;
  logic [2:0]    b_clk, b_tick, b_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_multi #(.N_CH(N), .DIV_W(DW), .DEF_DIV(DD), .DEF_EN(1'b1)) dut (
    .clk(clk), .reset(rst),
`ifdef CLK_DIV_SYNC_EN
    .sync_all(sy),
`endif
    .cfg_valid(vld), .cfg_ready(cfg_ready), .cfg_chan(chan), .cfg_div(div), .cfg_en(en),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  // Three channels leave cfg_chan == 3 out of range.
  clk_div_multi #(.N_CH(3), .DIV_W(DW), .DEF_DIV(3), .DEF_EN(1'b1)) dut_b (
    .clk(clk), .reset(b_rst),
`ifdef CLK_DIV_SYNC_EN
    .sync_all(1'b0),
`endif
    .cfg_valid(b_vld), .cfg_ready(b_ready), .cfg_chan(b_chan), .cfg_div(b_div), .cfg_en(1'b1),
    .clk_out(b_clk), .tick(b_tick), .pending(b_pend)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each running channel remembers the absolute edge number of its next wrap.
  longint      edge_t = 0;
  longint      nxt[N];
  int unsigned m_div[N], m_sdiv[N];
  bit          m_en[N], m_sen[N], m_clk[N], m_tick[N], m_pend[N];

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (int'(chan) >= N) return 1'b1;
    return !m_pend[chan];
  endfunction

  task automatic model_edge();
    bit xfer = vld && m_ready();
    edge_t++;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_div[c] = DD; m_en[c] = 1'b1; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
        m_pend[c] = 1'b0; nxt[c] = edge_t + DD;
      end else begin
        bit live = m_en[c] && (m_div[c] != 0);
        bit hit  = live && (edge_t == nxt[c]);
        if (sy || (m_pend[c] && (hit || !live))) begin
          if (m_pend[c]) begin
            m_div[c] = m_sdiv[c]; m_en[c] = m_sen[c]; m_pend[c] = 1'b0;
          end
          live = m_en[c] && (m_div[c] != 0);
          if (hit && !sy && live) begin
            m_clk[c] = !m_clk[c]; m_tick[c] = 1'b1;
          end else begin
            m_clk[c] = 1'b0; m_tick[c] = 1'b0;
          end
          nxt[c] = edge_t + m_div[c];
        end else if (hit) begin
          m_clk[c] = !m_clk[c]; m_tick[c] = 1'b1; nxt[c] = edge_t + m_div[c];
        end else begin
          m_tick[c] = 1'b0;
          if (!live) m_clk[c] = 1'b0;
        end
        if (xfer && int'(chan) == c) begin
          m_sdiv[c] = div; m_sen[c] = en; m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  // Inputs are already driven; one clock edge, compared against the model.
  task automatic step();
    logic [N-1:0] ec, et, ep;
    #1;
    chk("ready_model", cfg_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < N; c++) begin
      ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    chk("clk_out_model", clk_out, ec);
    chk("tick_model", tick, et);
    chk("pending_model", pending, ep);
  endtask

  task automatic do_write(input int c, input int d, input bit e);
    vld = 1'b1; chan = 2'(c); div = DW'(d); en = e;
    step();
    vld = 1'b0;
  endtask

  typedef struct {
    bit         rst, vld;
    logic [1:0] chan;
    logic [7:0] div;
    bit         en, rdy;
    logic [3:0] ck, tk, pd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input int c, input int d, input bit e,
                     input bit rd, input logic [3:0] ck, input logic [3:0] tk, input logic [3:0] pd);
    vec_t x;
    x.rst = r; x.vld = v; x.chan = 2'(c); x.div = 8'(d); x.en = e; x.rdy = rd;
    x.ck = ck; x.tk = tk; x.pd = pd;
    tbl.push_back(x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Row k: inputs applied before edge k, outputs expected after it.
    add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    for (int r = 1; r <= 4; r++) add(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'hF, 4'hF, 4'h0);
    for (int r = 6; r <= 9; r++) add(0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'h0, 4'hF, 4'h0);
    for (int r = 11; r <= 14; r++) add(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'hF, 4'hF, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 4'h0);
    add(0, 1, 1, 3, 1, 1, 4'hF, 4'h0, 4'h2);
    add(0, 0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h2);
    add(0, 0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h2);
    add(0, 0, 1, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    add(0, 0, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'h2, 4'h2, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'h2, 4'h0, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'hF, 4'hD, 4'h0);
    add(0, 0, 0, 0, 0, 1, 4'hD, 4'h2, 4'h0);

    // Out-of-range channel on the three-channel instance.
    @(posedge clk); #1;
    b_rst = 1'b0; b_vld = 1'b1; b_chan = 2'd3; b_div = 8'd7;
    #1; chk("oor_ready", b_ready, 1);
    @(posedge clk); #1;
    chk("oor_no_pending", b_pend, 3'b000);
    b_chan = 2'd2;
    #1; chk("b_ready_ch2", b_ready, 1);
    @(posedge clk); #1;
    chk("b_pending_ch2", b_pend, 3'b100);
    b_vld = 1'b0;
    #1; chk("b_ready_busy", b_ready, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; vld = tbl[i].vld; chan = tbl[i].chan; div = tbl[i].div; en = tbl[i].en;
      #1;
      chk("tbl_ready", cfg_ready, tbl[i].rdy);
      step();
      chk("tbl_clk_out", clk_out, tbl[i].ck);
      chk("tbl_tick", tick, tbl[i].tk);
      chk("tbl_pending", pending, tbl[i].pd);
    end
    vld = 1'b0; chan = '0;

    // Disable ch2 mid-period, then re-enable with D=2.
    do_write(2, 5, 0);
    repeat (10) step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("ch2_off_clk", clk_out[2], 0);
      chk("ch2_off_pend", pending[2], 0);
    end
    do_write(2, 2, 1);
    chk("ch2_pend_set", pending[2], 1);
    step();
    chk("ch2_idle_apply", pending[2], 0);
    chk("ch2_clk_a", clk_out[2], 0);
    step();
    chk("ch2_clk_b", clk_out[2], 0);
    step();
    chk("ch2_first_rise", clk_out[2], 1);
    chk("ch2_first_tick", tick[2], 1);

    // ch0: D=0 idles, then D=1 toggles every cycle.
    do_write(0, 0, 1);
    repeat (6) step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ch0_d0_clk", clk_out[0], 0);
      chk("ch0_d0_tick", tick[0], 0);
    end
    do_write(0, 1, 1);
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ch0_d1_tick", tick[0], 1);
      chk("ch0_d1_clk", clk_out[0], (k % 2 == 0) ? 1 : 0);
    end

    // Reset while ch3 has a shadow pending: shadow must be discarded.
    do_write(3, 2, 1);
    chk("ch3_pend_set", pending[3], 1);
    rst = 1'b1;
    #1; chk("ready_in_reset", cfg_ready, 0);
    step();
    chk("rst_clk_out", clk_out, 4'h0);
    chk("rst_tick", tick, 4'h0);
    chk("rst_pending", pending, 4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("post_rst_clk", clk_out, ((k / 5) % 2 == 1) ? 4'hF : 4'h0);
      chk("post_rst_tick", tick, (k % 5 == 0) ? 4'hF : 4'h0);
    end

`ifdef CLK_DIV_SYNC_EN
    do_write(0, 4, 1);
    do_write(1, 6, 1);
    repeat (9) step();
    sy = 1'b1;
    step();
    sy = 1'b0;
    chk("sync_clk", clk_out[1:0], 2'b00);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("sync_ch0", clk_out[0], (k >= 4) ? 1 : 0);
      chk("sync_ch1", clk_out[1], (k >= 6) ? 1 : 0);
    end
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 149) == 0);
      vld  = ($urandom_range(0, 2) == 0);
      chan = 2'($urandom_range(0, 3));
      div  = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 7));
      en   = ($urandom_range(0, 7) != 0);
`ifdef CLK_DIV_SYNC_EN
      sy   = ($urandom_range(0, 99) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- N_CH-channel programmable clock divider / tick generator; the parametrised successor to the single fixed-divisor divider.
- Each channel has its own runtime divisor, enable, toggled output clock and one-cycle tick strobe.
- Software/control FSM writes channel config through a valid/ready port.
- Updates are shadowed and applied glitch-free at the channel's next wrap.
- Feeds display refresh, debounce sampling and keypad scan timing in the calculator.

Parameters:
- N_CH, 4, number of independent divider channels (1..16).
- DIV_W, 32, width of divisor and per-channel counter.
- DEF_DIV, 5000, divisor loaded into every channel at reset.
- DEF_EN, 1, enable state of every channel at reset (1 = free-running from reset).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted
- cfg_chan  in  CHW  target channel; CHW = max(1, $clog2(N_CH))
- cfg_div  in  DIV_W  new divisor D
- cfg_en  in  1  new enable for target channel
- clk_out  out  N_CH  per-channel divided clock, period 2*D cycles, 50% duty
- tick  out  N_CH  per-channel strobe, high 1 cycle every D cycles
- pending  out  N_CH  shadow update waiting for wrap

Behaviour:
- Reset (sampled on posedge clk):
  - all counters = 0, clk_out = 0, tick = 0, pending = 0.
  - active divisor = DEF_DIV, enable = DEF_EN.
  - reset overrides any in-flight cfg transfer and discards shadow contents.
- Channel counting (enabled, D >= 1):
  - count increments each cycle.
  - At count == D-1: count <= 0, clk_out toggles, tick registered high for that one cycle; otherwise tick = 0.
  - D = 1: clk_out = clk/2, tick constantly high.
- Channel idle (enable = 0 or D = 0):
  - count held at 0, clk_out forced 0, tick 0.
  - Re-enabling restarts from count 0, clk_out 0; first toggle occurs D cycles after the enabling update is applied.
- Config handshake:
  - cfg_ready = !pending[cfg_chan] (combinational on cfg_chan), forced 0 during reset.
  - Transfer occurs when cfg_valid && cfg_ready on a posedge.
  - On transfer: shadow[cfg_chan] <= {cfg_en, cfg_div}, pending[cfg_chan] <= 1.
  - cfg_chan >= N_CH: cfg_ready = 1, write accepted and dropped, no state change.
- Update application (per channel):
  - Channel running: shadow applied on the cycle count == D_old-1. Counter wraps to 0 and the new D governs the next period. clk_out still toggles at that wrap. pending clears same cycle.
  - Channel idle: shadow applied the cycle after transfer; pending clears.
  - New enable = 0 applied at wrap: clk_out toggles is suppressed; clk_out forced 0 from that cycle.
- Simultaneous events:
  - A write accepted on the same cycle as an application for the same channel cannot occur, because ready = 0 while pending.
  - Writes to different channels are independent.
- Channels never interact; there is no phase relationship between channels unless the optional sync is compiled in.

Optional Feature:
- Macro CLK_DIV_SYNC_EN.
- Defined:
  - extra input port sync_all (1 bit).
  - When high, every enabled channel: count <= 0, clk_out <= 0, tick <= 0 next cycle. All channels become phase-aligned.
  - Pending shadows are applied in that same cycle.
  - reset has priority over sync_all.
- Undefined: port absent; channels free-run independently.

Test Plan:
- Reset, N_CH=4, DEF_DIV=5: every clk_out has first rise at cycle 5 after reset release and period 10. Tick asserted at cycles 5, 10, 15.
- Write ch1 D=3 en=1 while ch1 at count 1 of D=5: pending[1]=1 and cfg_ready low for ch1. Apply at count 4; next toggles 3 cycles apart. pending[1] clears at apply.
- Write ch2 en=0 mid-period, then en=1 D=2: clk_out[2] goes 0 at next wrap and stays 0. After re-enable, first rise 2 cycles after apply; idle apply happens 1 cycle after transfer.
- Write ch0 D=0: channel idle, clk_out[0]=0, tick[0]=0. Then write D=1: clk_out[0] toggles every cycle and tick[0] is constantly 1.
- Assert reset mid-period with ch3 pending: all outputs return to reset values and pending=0. Previous shadow is not applied after release.
- With CLK_DIV_SYNC_EN, channels at D=4 and D=6 offset: pulse sync_all. Both clk_out = 0 and counts = 0 next cycle; subsequent rises at +4 and +6.
